// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM state encoding and default width.
// Imported by controller and controller_datapath.
package gcd_pkg;
  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPARE,
    DONE
  } state_t;
endpackage

// File: rtl/controller_datapath.sv
// GCD datapath: A/B registers, input and subtractor muxes, comparator.
// Ports: clk, rst_n (sync, active-low), i_data, load/select controls in;
//   o_lt/o_gt/o_eq, o_a_zero/o_b_zero, o_a (register A) out.
module controller_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ld_a,
  input  logic             i_ld_b,
  input  logic             i_sel_in,
  input  logic             i_sel1,
  input  logic             i_sel2,
  output logic             o_lt,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_a_zero,
  output logic             o_b_zero,
  output logic [WIDTH-1:0] o_a
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_nxt;

  // sel1 picks the minuend, sel2 the subtrahend. B-A with A==0
  // gives B, so the same path copies B into A.
  assign w_x    = i_sel1 ? r_b : r_a;
  assign w_y    = i_sel2 ? r_a : r_b;
  assign w_diff = w_x - w_y;
  assign w_nxt  = i_sel_in ? i_data : w_diff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (i_ld_a) r_a <= w_nxt;
      if (i_ld_b) r_b <= w_nxt;
    end
  end

  assign o_lt     = r_a < r_b;
  assign o_gt     = r_a > r_b;
  assign o_eq     = r_a == r_b;
  assign o_a_zero = r_a == '0;
  assign o_b_zero = r_b == '0;
  assign o_a      = r_a;

endmodule

// File: rtl/controller.sv
// Iterative subtractive GCD engine: FSM sequencer over one datapath.
// Ports: clk, rst_n (sync, active-low), start, data_in; done, gcd_out.
// Macro GCD_ITER_COUNT_EN adds output iter_cnt (subtraction count).
module controller
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);

  state_t r_state;
  logic   r_done;

  logic w_ld_a, w_ld_b;
  logic w_sel_in, w_sel1, w_sel2;
  logic w_sub;
  logic w_lt, w_gt, w_eq;
  logic w_a_zero, w_b_zero;
  logic w_fin;

  controller_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (data_in),
    .i_ld_a  (w_ld_a),
    .i_ld_b  (w_ld_b),
    .i_sel_in(w_sel_in),
    .i_sel1  (w_sel1),
    .i_sel2  (w_sel2),
    .o_lt    (w_lt),
    .o_gt    (w_gt),
    .o_eq    (w_eq),
    .o_a_zero(w_a_zero),
    .o_b_zero(w_b_zero),
    .o_a     (gcd_out)
  );

  assign w_fin = w_eq | w_a_zero | w_b_zero;

  always_comb begin
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_sel_in = 1'b0;
    w_sel1   = 1'b0;
    w_sel2   = 1'b0;
    w_sub    = 1'b0;
    unique case (r_state)
      LOAD_A: begin
        w_sel_in = 1'b1;
        w_ld_a   = 1'b1;
      end
      LOAD_B: begin
        w_sel_in = 1'b1;
        w_ld_b   = 1'b1;
      end
      COMPARE: begin
        if (w_eq) begin
          w_ld_a = 1'b0;
        end else if (w_a_zero) begin
          w_ld_a = 1'b1;
          w_sel1 = 1'b1;
          w_sel2 = 1'b1;
        end else if (w_b_zero) begin
          w_ld_a = 1'b0;
        end else if (w_gt) begin
          w_ld_a = 1'b1;
          w_sub  = 1'b1;
        end else if (w_lt) begin
          w_ld_b = 1'b1;
          w_sel1 = 1'b1;
          w_sel2 = 1'b1;
          w_sub  = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] r_cnt;
  assign iter_cnt = r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      r_cnt   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD_A;
`ifdef GCD_ITER_COUNT_EN
            r_cnt   <= '0;
`endif
          end
        end
        LOAD_A:  r_state <= LOAD_B;
        LOAD_B:  r_state <= COMPARE;
        COMPARE: begin
          if (w_fin) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
`ifdef GCD_ITER_COUNT_EN
          if (w_sub && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
`endif
        end
        DONE: begin
          if (start) begin
            r_state <= LOAD_A;
            r_done  <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            r_cnt   <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed runs, per-cycle model check.
// Ports driven: clk, rst_n, start, data_in; observes done, gcd_out.
module tb_controller;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic         done;
  logic [W-1:0] gcd_out;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iter_cnt;
`endif

  int total = 0;
  int bad   = 0;

  controller #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .data_in(data_in),
    .done   (done),
    .gcd_out(gcd_out)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_cnt(iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Result and subtraction count from Euclid quotients.
  function automatic void gcd_model(input int a, input int b,
                                    output int g, output int s);
    int x, y, q, r;
    s = 0;
    if (a == 0) begin g = b; return; end
    if (b == 0) begin g = a; return; end
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    forever begin
      q = x / y;
      r = x % y;
      if (r == 0) begin s += q - 1; g = y; return; end
      s += q;
      x = y;
      y = r;
    end
  endfunction

  // Timeline model: 0 idle, 1 load A, 2 load B, 3 computing, 4 done.
  int m_ph = 0, m_left = 0, m_a = 0, m_res = 0, m_iter = 0;
  int m_g, m_s;
  bit m_done = 0, m_chk = 0, m_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_done = 0; m_res = 0; m_chk = 1; m_valid = 1;
    end else begin
      case (m_ph)
        0: if (start) m_ph = 1;
        1: begin m_a = int'(data_in); m_chk = 0; m_ph = 2; end
        2: begin
          gcd_model(m_a, int'(data_in), m_g, m_s);
          m_left = m_s;
          m_ph = 3;
        end
        3: begin
          if (m_left == 0) begin
            m_done = 1; m_chk = 1; m_res = m_g;
            m_iter = (m_s > 65535) ? 65535 : m_s;
            m_ph = 4;
          end else m_left--;
        end
        4: if (start) begin m_ph = 1; m_done = 0; end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_done", int'(done), int'(m_done));
      if (m_chk) check("cyc_gcd", int'(gcd_out), m_res);
`ifdef GCD_ITER_COUNT_EN
      if (m_done) check("cyc_iter", int'(iter_cnt), m_iter);
`endif
    end
  end

  // Start sampled at edge k; returns done at k+1 probe.
  task automatic launch(input int a, input int b, output int dk);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; data_in = W'(a);
    dk = int'(done);
    @(posedge clk); #1; data_in = W'(b);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 70000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic run(input int a, input int b, output int lat,
                     output int dk);
    launch(a, b, dk);
    wait_done(lat);
  endtask

  int lat, dk;

  initial begin
    rst_n = 1'b0; start = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_done", int'(done), 0);
    check("rst_gcd", int'(gcd_out), 0);

    run(56, 98, lat, dk);
    check("b_lat", lat, 7);
    check("b_gcd", int'(gcd_out), 14);
`ifdef GCD_ITER_COUNT_EN
    check("b_iter", int'(iter_cnt), 4);
`endif
    repeat (3) @(posedge clk);
    #1 check("b_hold", int'(gcd_out), 14);

    run(21, 14, lat, dk);
    check("bb_drop", dk, 0);
    check("bb_gcd", int'(gcd_out), 7);

    run(25, 25, lat, dk);
    check("eq_lat", lat, 3);
    check("eq_gcd", int'(gcd_out), 25);
`ifdef GCD_ITER_COUNT_EN
    check("eq_iter", int'(iter_cnt), 0);
`endif

    run(0, 36, lat, dk);
    check("z0_gcd", int'(gcd_out), 36);
    run(48, 0, lat, dk);
    check("z1_gcd", int'(gcd_out), 48);
    run(0, 0, lat, dk);
    check("z2_gcd", int'(gcd_out), 0);
    check("z2_lat", lat, 3);

    run(65535, 1, lat, dk);
    check("ex_gcd", int'(gcd_out), 1);
    check("ex_lat", lat, 3 + 65534);
`ifdef GCD_ITER_COUNT_EN
    check("ex_iter", int'(iter_cnt), 65534);
`endif

    launch(56, 98, dk);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("mr_done", int'(done), 0);
    check("mr_gcd", int'(gcd_out), 0);
    repeat (2) @(posedge clk);
    #1 check("mr_idle", int'(done), 0);

    run(12, 18, lat, dk);
    check("mr_new", int'(gcd_out), 6);

    repeat (2) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
